rr_burst_arbiter: RTL
=====================

RR_BURST_ARBITER -- requirements
Module: rr_burst_arbiter

Interface
REQ-001 SHALL have parameter NUM_CH, default 2: number of requester channels, range 2..8.
REQ-002 SHALL have parameter BURST_LEN, default 4: beats per burst, range 1..16.
REQ-003 SHALL have parameter ARB_MODE, default 0: 0 = round-robin, 1 = fixed priority with channel 0 highest.
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-006 SHALL have port ch_address, input, NUM_CH x 32: per-channel burst start address.
REQ-007 SHALL have port ch_read, input, NUM_CH: per-channel read request.
REQ-008 SHALL have port ch_write, input, NUM_CH: per-channel write request.
REQ-009 SHALL have port ch_wdata, input, NUM_CH x 64: per-channel write beat.
REQ-010 SHALL have port ch_rdata, output, 64: read beat, broadcast to all channels.
REQ-011 SHALL have port ch_resp, output, NUM_CH: per-channel beat response.
REQ-012 SHALL have ports bmem_address (output, 32), bmem_read (output, 1), bmem_write (output, 1) and bmem_wdata (output, 64) to burst memory.
REQ-013 SHALL have ports bmem_rdata (input, 64) and bmem_resp (input, 1) from burst memory; bmem_resp high marks one beat transferred.

Function
REQ-014 SHALL implement the FSM states IDLE, BUSY and RELEASE.
REQ-015 SHALL, in IDLE, when any channel has ch_read|ch_write, register the winner as grant and enter BUSY next cycle; bmem_read/bmem_write SHALL first assert in that BUSY cycle (1-cycle arbitration latency).
REQ-016 SHALL, in round-robin mode, search from priority pointer ptr upward, wrapping modulo NUM_CH.
REQ-017 SHALL, in fixed mode, grant the lowest-index requester; ptr is ignored.
REQ-018 SHALL, in BUSY, drive bmem_address, bmem_wdata and bmem_read/bmem_write from the granted channel only; all other bmem outputs SHALL be 0.
REQ-019 SHALL latch the operation (read or write) at grant; if a channel asserts both, write SHALL win.
REQ-020 SHALL route ch_resp[grant] = bmem_resp in BUSY; every other ch_resp bit SHALL be 0 at all times.
REQ-021 SHALL keep a beat counter of width clog2(BURST_LEN)+1, cleared at grant and incremented on each bmem_resp in BUSY.
REQ-022 SHALL, on the BURST_LEN-th bmem_resp, enter RELEASE next cycle, deassert bmem_read/bmem_write, and set ptr = (grant+1) mod NUM_CH.
REQ-023 SHALL spend exactly 1 cycle in RELEASE with no grant, ignoring stale requests, then return to IDLE; back-to-back bursts are therefore separated by 2 idle bus cycles.
REQ-024 SHALL hold the grant until BURST_LEN beats complete even if the granted channel drops its request mid-burst (a burst cannot be aborted).
REQ-025 SHALL ignore bmem_resp in IDLE and RELEASE.
REQ-026 SHALL, with NUM_CH=2 and ARB_MODE=0, be a drop-in replacement for the existing two-channel i/d arbiter (channel 0 = icache, channel 1 = dcache).

Reset
REQ-027 SHALL, on rst, set the state to IDLE, ptr to 0, grant to 0 and the beat count to 0.
REQ-028 SHALL drive every output to 0 while rst is high and in the cycle after its release.
REQ-029 SHALL, on rst asserted mid-burst, abandon the burst immediately; no ch_resp SHALL be emitted for remaining beats.

Structure
REQ-030 SHALL place the state enum (arb_state_t) and the BURST_LEN/ARB_MODE encodings in rv32i_types.
REQ-031 SHALL place the pointer-rotated priority pick in one sub-module, rr_pick (NUM_CH-wide request vector plus ptr in, one-hot grant out), which is combinational.

Verification
REQ-032 SHALL cover: rst high then release, ch_read=2'b01 addr 0x100 -> bmem_read=1, bmem_address=0x100 one cycle later; 4 resp beats -> ch_resp[0] pulses 4 times, ch_resp[1] stays 0.
REQ-033 SHALL cover: both channels read continuously, ARB_MODE=0 -> grants alternate 0,1,0,1 with a 2-cycle gap between bursts.
REQ-034 SHALL cover: same stimulus as REQ-033 with ARB_MODE=1 -> channel 0 is granted every burst.
REQ-035 SHALL cover: ch1 write with wdata beats 0xA..0xD, BURST_LEN=4 -> bmem_write=1, bmem_wdata follows ch_wdata[1], RELEASE after the 4th resp.
REQ-036 SHALL cover: ch0 drops ch_read after beat 1 -> grant held and ch_resp[0] still pulses for beats 2..4.
REQ-037 SHALL cover: rst asserted after beat 2 -> IDLE next cycle, all outputs 0, ptr=0.

Source files
------------

// File: rtl/rv32i_types.sv
// Shared types for the burst arbiter: FSM state encoding and the
// arbitration-mode / burst-length encodings used as parameter values.
package rv32i_types;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    BUSY    = 2'd1,
    RELEASE = 2'd2
  } arb_state_t;

  localparam int ARB_MODE_RR       = 0;
  localparam int ARB_MODE_FIXED    = 1;
  localparam int BURST_LEN_DEFAULT = 4;

endpackage

// File: rtl/rr_pick.sv
// Combinational pointer-rotated priority pick: the first requester found
// scanning upward from ptr (wrapping) wins; output is one-hot.
module rr_pick #(
  parameter int NUM_CH = 2,
  parameter int PW     = $clog2(NUM_CH)
) (
  input  logic [NUM_CH-1:0] req,
  input  logic [PW-1:0]     ptr,
  output logic [NUM_CH-1:0] gnt
);

  always_comb begin
    int   idx;
    logic found;
    gnt   = '0;
    idx   = 0;
    found = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      idx = (int'(ptr) + i) % NUM_CH;
      if (!found && req[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rr_burst_arbiter.sv
// Multi-channel burst arbiter: one channel at a time owns burst memory for
// BURST_LEN beats, followed by a one-cycle RELEASE before the next grant.
module rr_burst_arbiter
  import rv32i_types::*;
#(
  parameter int NUM_CH    = 2,
  parameter int BURST_LEN = BURST_LEN_DEFAULT,
  parameter int ARB_MODE  = ARB_MODE_RR
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_CH*32-1:0] ch_address,
  input  logic [NUM_CH-1:0]    ch_read,
  input  logic [NUM_CH-1:0]    ch_write,
  input  logic [NUM_CH*64-1:0] ch_wdata,
  output logic [63:0]          ch_rdata,
  output logic [NUM_CH-1:0]    ch_resp,
  output logic [31:0]          bmem_address,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [63:0]          bmem_wdata,
  input  logic [63:0]          bmem_rdata,
  input  logic                 bmem_resp
);

  localparam int GW = $clog2(NUM_CH);
  localparam int CW = $clog2(BURST_LEN) + 1;

  arb_state_t        state;
  logic [GW-1:0]     ptr;
  logic [GW-1:0]     grant;
  logic [CW-1:0]     beat_cnt;
  logic              op_rd;
  logic              op_wr;

  logic [NUM_CH-1:0] req;
  logic [NUM_CH-1:0] pick_gnt;
  logic [GW-1:0]     pick_ptr;
  logic [GW-1:0]     pick_idx;
  logic [GW-1:0]     next_ptr;
  logic              pick_wr;
  logic              last_beat;
  logic              busy;

  assign req      = ch_read | ch_write;
  assign pick_ptr = (ARB_MODE == ARB_MODE_FIXED) ? '0 : ptr;

  rr_pick #(.NUM_CH(NUM_CH)) u_pick (
    .req (req),
    .ptr (pick_ptr),
    .gnt (pick_gnt)
  );

  always_comb begin
    pick_idx = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (pick_gnt[i]) pick_idx = GW'(i);
    end
  end

  // A channel raising both read and write is treated as a write.
  assign pick_wr   = |(ch_write & pick_gnt);
  assign next_ptr  = (int'(grant) == NUM_CH - 1) ? '0 : grant + GW'(1);
  assign last_beat = bmem_resp && (beat_cnt == CW'(BURST_LEN - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      grant    <= '0;
      beat_cnt <= '0;
      op_rd    <= 1'b0;
      op_wr    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (|req) begin
            grant    <= pick_idx;
            beat_cnt <= '0;
            op_wr    <= pick_wr;
            op_rd    <= !pick_wr;
            state    <= BUSY;
          end
        end
        BUSY: begin
          // Request drops are ignored here: a burst always runs to completion.
          if (bmem_resp) begin
            beat_cnt <= beat_cnt + CW'(1);
            if (last_beat) begin
              op_rd <= 1'b0;
              op_wr <= 1'b0;
              ptr   <= next_ptr;
              state <= RELEASE;
            end
          end
        end
        RELEASE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs are forced low while rst is high so a burst cut by reset stops at once.
  assign busy         = (state == BUSY) && !rst;
  assign bmem_read    = op_rd && !rst;
  assign bmem_write   = op_wr && !rst;
  assign bmem_address = busy ? ch_address[int'(grant)*32 +: 32] : '0;
  assign bmem_wdata   = busy ? ch_wdata[int'(grant)*64 +: 64] : '0;
  assign ch_rdata     = busy ? bmem_rdata : '0;

  always_comb begin
    ch_resp = '0;
    if (busy) ch_resp[grant] = bmem_resp;
  end

endmodule
